multi_sensor_adc_sequencer: RTL

Parametrised successor to the single-sensor/ADC control path between the ISO/IEC 14443A app layer (via adapter) and the analogue sensor/ADC.
- Drives NUM_CHANNELS sensors sharing one ADC.
- Performs settle timing, conversion handshake with timeout, and 2^N oversampled averaging.
- Returns one result per request over a valid/ready handshake.

---
 rtl/multi_sensor_seq_pkg.sv | 34 +++
 rtl/sensor_seq_timer.sv | 28 ++
 rtl/multi_sensor_adc_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_sensor_seq_pkg.sv
// Shared types and width helpers for the multi-sensor ADC sequencer.
package multi_sensor_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_GAP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK          = 2'b00,
    STATUS_TIMEOUT     = 2'b01,
    STATUS_BAD_CHANNEL = 2'b10
  } status_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ch_width(input int n);
    return max_int(1, $clog2(n));
  endfunction

  function automatic int avg_width(input int m);
    return max_int(1, $clog2(m + 1));
  endfunction

  function automatic int timer_width(input int s, input int t);
    return max_int(1, $clog2(max_int(s, t) + 1));
  endfunction

endpackage

// File: rtl/sensor_seq_timer.sv
// Loadable down-counter shared by the settle and conversion-timeout phases.
module sensor_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] value,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Asserted during the final cycle of the loaded interval.
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/multi_sensor_adc_sequencer.sv
// Multi-channel sensor/ADC sequencer: settle, convert with timeout, 2^N averaging.
module multi_sensor_adc_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADC_WIDTH      = 16,
  parameter int CONFIG_WIDTH   = 3,
  parameter int MAX_AVG_LOG2   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      abort,
  input  logic                                                      req_valid,
  output logic                                                      req_ready,
  input  logic [multi_sensor_seq_pkg::ch_width(NUM_CHANNELS)-1:0]   req_channel,
  input  logic [CONFIG_WIDTH-1:0]                                   req_config,
  input  logic [multi_sensor_seq_pkg::avg_width(MAX_AVG_LOG2)-1:0]  req_avg_log2,
  output logic                                                      res_valid,
  input  logic                                                      res_ready,
  output logic [ADC_WIDTH-1:0]                                      res_value,
  output logic [multi_sensor_seq_pkg::ch_width(NUM_CHANNELS)-1:0]   res_channel,
  output logic [1:0]                                                res_status,
  output logic [CONFIG_WIDTH-1:0]                                   sens_config,
  output logic [NUM_CHANNELS-1:0]                                   sens_enable,
  output logic [NUM_CHANNELS-1:0]                                   sens_read,
  output logic                                                      adc_enable,
  output logic                                                      adc_read,
  input  logic                                                      adc_conversion_complete,
  input  logic [ADC_WIDTH-1:0]                                      adc_value
);
  import multi_sensor_seq_pkg::*;

  localparam int CH_W  = ch_width(NUM_CHANNELS);
  localparam int AVG_W = avg_width(MAX_AVG_LOG2);
  localparam int ACC_W = ADC_WIDTH + MAX_AVG_LOG2;
  localparam int TMR_W = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);

  state_e                state;
  status_e               status_q;
  logic [CH_W-1:0]       ch_q;
  logic [AVG_W-1:0]      avg_q;
  logic [ACC_W-1:0]      acc_q, acc_next;
  logic [MAX_AVG_LOG2:0] cnt_q, cnt_next, cnt_target;
  logic [ADC_WIDTH-1:0]  avg_value;
  logic [NUM_CHANNELS-1:0] ch_onehot, req_onehot;
  logic [AVG_W-1:0]      avg_sat;
  logic                  accept, ch_ok;
  logic                  tmr_load, tmr_dec, tmr_last;
  logic [TMR_W-1:0]      tmr_value;

  assign res_status = status_q;
  assign accept     = (state == ST_IDLE) && req_valid && req_ready;
  assign ch_ok      = int'(req_channel) < NUM_CHANNELS;
  assign avg_sat    = (int'(req_avg_log2) > MAX_AVG_LOG2) ? AVG_W'(MAX_AVG_LOG2) : req_avg_log2;
  assign req_onehot = NUM_CHANNELS'(1) << req_channel;
  assign ch_onehot  = NUM_CHANNELS'(1) << ch_q;
  assign acc_next   = acc_q + ACC_W'(adc_value);
  assign cnt_next   = cnt_q + (MAX_AVG_LOG2 + 1)'(1);
  assign cnt_target = (MAX_AVG_LOG2 + 1)'(1) << avg_q;
  assign avg_value  = ADC_WIDTH'(acc_next >> avg_q);

  // One timer: loaded with the settle length on accept, reloaded with the
  // timeout length on every entry to CONVERT.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = TMR_W'(TIMEOUT_CYCLES);
    unique case (state)
      ST_IDLE: begin
        tmr_load = accept;
        if (SETTLE_CYCLES != 0) tmr_value = TMR_W'(SETTLE_CYCLES);
      end
      ST_SETTLE: tmr_load = tmr_last;
      ST_GAP:    tmr_load = 1'b1;
      default:   tmr_load = 1'b0;
    endcase
  end

  assign tmr_dec = (state == ST_SETTLE) || (state == ST_CONVERT);

  sensor_seq_timer #(.WIDTH(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .value (tmr_value),
    .last  (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      status_q    <= STATUS_OK;
      ch_q        <= '0;
      avg_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      req_ready   <= 1'b0;
      res_valid   <= 1'b0;
      res_value   <= '0;
      res_channel <= '0;
      sens_config <= '0;
      sens_enable <= '0;
      sens_read   <= '0;
      adc_enable  <= 1'b0;
      adc_read    <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      status_q    <= STATUS_OK;
      req_ready   <= 1'b0;
      res_valid   <= 1'b0;
      res_value   <= '0;
      res_channel <= '0;
      sens_enable <= '0;
      sens_read   <= '0;
      adc_enable  <= 1'b0;
      adc_read    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            ch_q      <= req_channel;
            avg_q     <= avg_sat;
            acc_q     <= '0;
            cnt_q     <= '0;
            if (!ch_ok) begin
              state       <= ST_DONE;
              res_valid   <= 1'b1;
              res_value   <= '0;
              res_channel <= req_channel;
              status_q    <= STATUS_BAD_CHANNEL;
            end else begin
              sens_config <= req_config;
              sens_enable <= req_onehot;
              adc_enable  <= 1'b1;
              if (SETTLE_CYCLES == 0) begin
                state     <= ST_CONVERT;
                sens_read <= req_onehot;
                adc_read  <= 1'b1;
              end else begin
                state <= ST_SETTLE;
              end
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_last) begin
            state     <= ST_CONVERT;
            sens_read <= ch_onehot;
            adc_read  <= 1'b1;
          end
        end
        ST_CONVERT: begin
          // A completion in the timeout cycle is still accepted.
          if (adc_conversion_complete) begin
            acc_q     <= acc_next;
            cnt_q     <= cnt_next;
            sens_read <= '0;
            adc_read  <= 1'b0;
            if (cnt_next == cnt_target) begin
              state       <= ST_DONE;
              sens_enable <= '0;
              adc_enable  <= 1'b0;
              res_valid   <= 1'b1;
              res_value   <= avg_value;
              res_channel <= ch_q;
              status_q    <= STATUS_OK;
            end else begin
              state <= ST_GAP;
            end
          end else if (tmr_last) begin
            state       <= ST_DONE;
            sens_enable <= '0;
            sens_read   <= '0;
            adc_enable  <= 1'b0;
            adc_read    <= 1'b0;
            res_valid   <= 1'b1;
            res_value   <= '0;
            res_channel <= ch_q;
            status_q    <= STATUS_TIMEOUT;
          end
        end
        ST_GAP: begin
          state     <= ST_CONVERT;
          sens_read <= ch_onehot;
          adc_read  <= 1'b1;
        end
        ST_DONE: begin
          if (res_ready) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_value   <= '0;
            res_channel <= '0;
            status_q    <= STATUS_OK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
